count4: RTL and testbench
=========================

Name: count4

Overview:
- 4-bit synchronous up/down counter with count-enable and asynchronous active-high reset.
- General-purpose event/position counter used as a leaf block.
- Single registered output that wraps modulo 16 in both directions.

Parameters:
- WIDTH, 4, counter width in bits. The count range is 0 to 2^WIDTH-1. Only the default is required to be verified.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high; forces count to 0.
- enable  input  1  count enable; 1 = step by one on the next rising edge, 0 = hold.
- upDown  input  1  direction; 1 = increment, 0 = decrement. Only meaningful when enable=1.
- count  output  WIDTH  current counter value, driven directly from the register.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset:
  - rst=1 forces count to 0 immediately, without waiting for a clock edge.
  - count stays 0 for as long as rst is held, regardless of enable or upDown.
- Reset release:
  - On deassertion, the first rising edge with rst=0 applies the normal update rule from 0.
  - Example: enable=1, upDown=1 gives count=1 after that edge.
- Update rule, evaluated at each rising edge of clk while rst=0:
  - enable=1, upDown=1: count <= count + 1, modulo 2^WIDTH.
  - enable=1, upDown=0: count <= count - 1, modulo 2^WIDTH.
  - enable=0: count <= count (hold). upDown is ignored.
- Wrap-around:
  - Up from 15 gives 0.
  - Down from 0 gives 15.
  - No carry/borrow output and no saturation.
- Latency:
  - One clock edge from inputs to the new count.
  - count is stable between edges; the update is visible after the rising edge and before the following falling edge.
- Simultaneous events:
  - rst has priority over enable and upDown.
  - rst asserted in the same cycle as an enabled count gives 0.
- Reset mid-operation: asserting rst at any count value returns count to 0; counting resumes from 0 after release.
- Input timing:
  - enable and upDown are sampled only at rising edges.
  - Changes between edges have no effect on count.
- Arithmetic: unsigned, WIDTH bits, with the carry/borrow discarded.
- Power-up: the count value is undefined until the first rst assertion. Benches must assert rst first.

Test Plan:
- Reset then count up: rst=1, enable=1, upDown=1 for 1 cycle, then rst=0 for 4 rising edges -> count reads 1,2,3,4 after successive edges. count=0 while rst=1.
- Reset mid-count: from count=4, assert rst for 1 cycle, release, then run 2 edges with enable=1, upDown=1 -> count=0 during reset, then 1, then 2.
- Down with wrap: from count=0, enable=1, upDown=0 for 3 edges -> 15, 14, 13. Then from count=15 counting up for 1 edge -> 0.
- Hold: enable=0, toggle upDown every cycle for 5 edges at count=7 -> count remains 7 throughout.
- Asynchronous reset: at count=9, raise rst midway between rising edges -> count becomes 0 before the next rising edge. count stays 0 through edges while rst=1, with enable=1.
- Direction change: from reset, count up 3 edges (3), then upDown=0 for 5 edges -> 2,1,0,15,14. A reference model comparison at every falling edge must match throughout.

Source files
------------

// File: rtl/count4.sv
// count4: WIDTH-bit up/down counter with count enable, wrapping modulo 2^WIDTH,
// asynchronously cleared by an active-high reset.
module count4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             upDown,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q, count_d;
    always_comb begin
        count_d = enable ? (upDown ? count_q + WIDTH'(1) : count_q - WIDTH'(1)) : count_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end
    assign count = count_q;
endmodule

// File: tb/tb_count4.sv
// tb_count4: directed self-checking bench for count4; inputs change and outputs
// are sampled on falling edges, away from the active rising edge.
module tb_count4;
    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       upDown;
    logic [3:0] count;
    int checks = 0;
    int errors = 0;

    count4 dut (.clk(clk), .rst(rst), .enable(enable), .upDown(upDown), .count(count));

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step(input logic en, input logic ud);
        enable = en;
        upDown = ud;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; enable = 1'b1; upDown = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (count !== 4'd0) begin errors++; $display("FAIL reset_hold: count=%0d expected 0", count); end
        end
    endtask

    task automatic test_count_up;
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b1);
            checks++;
            if (count !== 4'(i)) begin errors++; $display("FAIL count_up: count=%0d expected %0d", count, i); end
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0] exp_v [2] = '{4'd1, 4'd2};
        rst = 1'b1;
        #1;
        checks++;
        if (count !== 4'd0) begin errors++; $display("FAIL reset_mid_async: count=%0d expected 0", count); end
        step(1'b1, 1'b1);
        checks++;
        if (count !== 4'd0) begin errors++; $display("FAIL reset_mid_held: count=%0d expected 0", count); end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1);
            checks++;
            if (count !== exp_v[i]) begin errors++; $display("FAIL reset_mid_resume: count=%0d expected %0d", count, exp_v[i]); end
        end
    endtask

    task automatic test_down_wrap;
        logic [3:0] exp_v [6] = '{4'd15, 4'd14, 4'd13, 4'd14, 4'd15, 4'd0};
        logic       dir_v [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        rst = 1'b1;
        step(1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, dir_v[i]);
            checks++;
            if (count !== exp_v[i]) begin errors++; $display("FAIL down_wrap[%0d]: count=%0d expected %0d", i, count, exp_v[i]); end
        end
    endtask

    task automatic test_hold;
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1);
        checks++;
        if (count !== 4'd7) begin errors++; $display("FAIL hold_setup: count=%0d expected 7", count); end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, i[0]);
            checks++;
            if (count !== 4'd7) begin errors++; $display("FAIL hold[%0d]: count=%0d expected 7", i, count); end
        end
    endtask

    task automatic test_async_reset;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        checks++;
        if (count !== 4'd9) begin errors++; $display("FAIL async_setup: count=%0d expected 9", count); end
        enable = 1'b1; upDown = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (count !== 4'd0) begin errors++; $display("FAIL async_reset: count=%0d expected 0 before edge", count); end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1);
            checks++;
            if (count !== 4'd0) begin errors++; $display("FAIL async_held[%0d]: count=%0d expected 0", i, count); end
        end
    endtask

    task automatic test_direction_change;
        logic [3:0] exp_v [8] = '{4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0, 4'd15, 4'd14};
        logic [3:0] model = 4'd0;
        logic       ud;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ud = (i < 3);
            model = ud ? model + 4'd1 : model - 4'd1;
            step(1'b1, ud);
            checks++;
            if (count !== exp_v[i]) begin errors++; $display("FAIL dir_change[%0d]: count=%0d expected %0d", i, count, exp_v[i]); end
            checks++;
            if (count !== model) begin errors++; $display("FAIL dir_model[%0d]: count=%0d model %0d", i, count, model); end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_reset_mid();
        test_down_wrap();
        test_hold();
        test_async_reset();
        test_direction_change();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
